// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b memory types plus the arbiter's state and port encodings.
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Arbiter FSM states: idle, instruction port granted, data port granted.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2
  } lc3b_arb_state;

  // Requester identity, used to remember which port was served last.
  typedef enum logic {
    port_inst = 1'b0,
    port_data = 1'b1
  } lc3b_mem_port;

  localparam lc3b_word      WORD_ZERO  = 16'h0000;
  localparam lc3b_mem_wmask WMASK_ZERO = 2'b00;

endpackage

// File: rtl/mem_arbiter_mux2.sv
// Word-wide 2:1 multiplexer; sel_i=1 selects b_i.
module mem_arbiter_mux2
  import mem_arbiter_pkg::*;
(
  input  logic     sel_i,
  input  lc3b_word a_i,
  input  lc3b_word b_i,
  output lc3b_word y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one LC-3b memory port between the
// instruction-fetch and data requesters. Data wins over instruction by
// default; defining ARB_ROUND_ROBIN_EN makes simultaneous requests
// alternate between the two ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  // instruction requester
  input  logic          i_read,
  input  lc3b_word      i_address,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  // data requester
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_byte_enable,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  // physical memory
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata
);

  lc3b_arb_state state_q, state_d;
  logic          d_req;
  logic          grant_data;
  lc3b_word      addr_sel;

`ifdef ARB_ROUND_ROBIN_EN
  lc3b_mem_port  last_grant_q, last_grant_d;
`endif

  assign d_req = d_read | d_write;

  // Pick the winning port for a request seen in S_IDLE.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the port that was not served last goes first.
    grant_data = d_req & (~i_read | (last_grant_q == port_inst));
`else
    grant_data = d_req;
`endif
  end

  // Next-state logic: grant from idle, release on the memory response.
  always_comb begin
    state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (d_req || i_read) begin
          state_d = grant_data ? S_DATA : S_INST;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_data ? port_data : port_inst;
`endif
        end
      end
      S_INST, S_DATA: begin
        // A requester that drops its request early still holds the grant
        // until memory answers, so the outstanding access is not orphaned.
        if (mem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant state register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= port_inst;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  mem_arbiter_mux2 u_addr_mux (
    .sel_i (state_q == S_DATA),
    .a_i   (i_address),
    .b_i   (d_address),
    .y_o   (addr_sel)
  );

  // Route the granted requester to memory and the response back to it.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = WORD_ZERO;
    mem_wdata       = WORD_ZERO;
    mem_byte_enable = WMASK_ZERO;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    unique case (state_q)
      S_INST: begin
        mem_read    = i_read;
        mem_address = addr_sel;
        i_resp      = mem_resp;
      end
      S_DATA: begin
        // Read and write together are treated as a write.
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_address     = addr_sel;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_byte_enable;
        d_resp          = mem_resp;
      end
      default: begin
        // Idle: memory is quiet and any stray response is dropped.
      end
    endcase
  end

  // Read data fans out to both ports; only the resp strobe qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, a tie-break
// sequence whose expectations depend on ARB_ROUND_ROBIN_EN, and randomized
// traffic checked against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read, d_write;
  logic [15:0] d_address, d_wdata;
  logic [1:0]  d_byte_enable;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        mr;
    logic [15:0] mrd;
    logic [69:0] exp;
  } vec_t;

  // Expected output bundle: {mem_read, mem_write, addr, wdata, be, i_resp, d_resp, i_rdata, d_rdata}
  function automatic logic [69:0] ex(logic mr, logic mw, logic [15:0] a, logic [15:0] wd,
                                     logic [1:0] be, logic ir, logic dr, logic [15:0] rd);
    return {mr, mw, a, wd, be, ir, dr, rd, rd};
  endfunction

  function automatic vec_t row(logic r, logic ir, logic [15:0] ia, logic dr, logic dw,
                               logic [15:0] da, logic [15:0] wd, logic [1:0] be,
                               logic mr, logic [15:0] mrd, logic [69:0] e);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.wd = wd; v.be = be; v.mr = mr; v.mrd = mrd; v.exp = e;
    return v;
  endfunction

  function automatic logic [69:0] actual();
    return {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
            i_resp, d_resp, i_rdata, d_rdata};
  endfunction

  task automatic check(string nm, logic [69:0] e);
    logic [69:0] a;
    a = actual();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; i_read = v.ir; i_address = v.ia;
    d_read = v.dr; d_write = v.dw; d_address = v.da; d_wdata = v.wd;
    d_byte_enable = v.be; mem_resp = v.mr; mem_rdata = v.mrd;
  endtask

  // Entered 1 time unit after a rising edge; checks at mid-cycle.
  task automatic apply(vec_t v, string nm);
    drive(v);
    #4;
    check(nm, v.exp);
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns memory, and who was served last.
  int m_owner;   // 0 none, 1 instruction, 2 data
  int m_last;    // 1 instruction, 2 data

  function automatic logic [69:0] model_out();
    logic [69:0] e;
    e = ex(1'b0, 1'b0, 16'h0, 16'h0, 2'b0, 1'b0, 1'b0, mem_rdata);
    if (m_owner == 1)
      e = ex(i_read, 1'b0, i_address, 16'h0, 2'b0, mem_resp, 1'b0, mem_rdata);
    else if (m_owner == 2)
      e = ex(d_read && !d_write, d_write, d_address, d_wdata, d_byte_enable,
             1'b0, mem_resp, mem_rdata);
    return e;
  endfunction

  task automatic model_step();
    bit wants_d, wants_i;
    wants_d = d_read || d_write;
    wants_i = i_read;
    if (rst) begin
      m_owner = 0;
      m_last  = 1;
    end else if (m_owner == 0) begin
      if (wants_d && wants_i) m_owner = (RR && m_last == 2) ? 1 : 2;
      else if (wants_d)       m_owner = 2;
      else if (wants_i)       m_owner = 1;
      if (m_owner != 0) m_last = m_owner;
    end else if (mem_resp) begin
      m_owner = 0;
    end
  endtask

  vec_t tbl[29];
  vec_t hs[14];
  logic [69:0] Z;

  initial begin
    rst = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_address = 0; d_wdata = 0; d_byte_enable = 0; mem_resp = 0; mem_rdata = 0;
    Z = '0;

    // Directed table: rst, ir, ia, dr, dw, da, wd, be, mr, mrd, expected
    tbl[0]  = row(1,1,16'h3000,0,0,0,0,0,0,16'h5555, ex(0,0,0,0,0,0,0,16'h5555));
    tbl[1]  = row(0,1,16'h3000,0,0,0,0,0,0,16'h0000, Z);
    tbl[2]  = row(0,1,16'h3000,0,0,0,0,0,0,16'h0000, ex(1,0,16'h3000,0,0,0,0,0));
    tbl[3]  = row(0,1,16'h3000,0,0,0,0,0,0,16'h0000, ex(1,0,16'h3000,0,0,0,0,0));
    tbl[4]  = row(0,1,16'h3000,0,0,0,0,0,1,16'h1234, ex(1,0,16'h3000,0,0,1,0,16'h1234));
    tbl[5]  = row(0,0,16'h3000,0,0,0,0,0,0,16'h0000, Z);
    tbl[6]  = row(0,0,0,0,1,16'h4002,16'hBEEF,2'b10,0,16'h0000, Z);
    tbl[7]  = row(0,0,0,0,1,16'h4002,16'hBEEF,2'b10,0,16'h0000, ex(0,1,16'h4002,16'hBEEF,2'b10,0,0,0));
    tbl[8]  = row(0,0,0,0,1,16'h4002,16'hBEEF,2'b10,1,16'h0000, ex(0,1,16'h4002,16'hBEEF,2'b10,0,1,0));
    tbl[9]  = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);
    tbl[10] = row(0,0,0,0,0,0,0,0,1,16'hABCD, ex(0,0,0,0,0,0,0,16'hABCD));
    tbl[11] = row(0,1,16'h1000,0,0,0,0,0,0,16'h0000, Z);
    tbl[12] = row(0,1,16'h1000,0,0,0,0,0,0,16'h0000, ex(1,0,16'h1000,0,0,0,0,0));
    tbl[13] = row(0,1,16'h1000,0,0,0,0,0,1,16'h0042, ex(1,0,16'h1000,0,0,1,0,16'h0042));
    tbl[14] = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);
    tbl[15] = row(0,0,0,1,0,16'h2222,0,0,0,16'h0000, Z);
    tbl[16] = row(0,0,0,1,0,16'h2222,0,0,0,16'h0000, ex(1,0,16'h2222,0,0,0,0,0));
    tbl[17] = row(1,0,0,1,0,16'h2222,0,0,0,16'h0000, ex(1,0,16'h2222,0,0,0,0,0));
    tbl[18] = row(0,0,0,0,0,16'h2222,0,0,1,16'h7777, ex(0,0,0,0,0,0,0,16'h7777));
    tbl[19] = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);
    tbl[20] = row(0,0,0,1,1,16'h0010,16'h00FF,2'b11,0,16'h0000, Z);
    tbl[21] = row(0,0,0,1,1,16'h0010,16'h00FF,2'b11,0,16'h0000, ex(0,1,16'h0010,16'h00FF,2'b11,0,0,0));
    tbl[22] = row(0,0,0,1,1,16'h0010,16'h00FF,2'b11,1,16'h0000, ex(0,1,16'h0010,16'h00FF,2'b11,0,1,0));
    tbl[23] = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);
    tbl[24] = row(0,1,16'h0400,0,0,0,0,0,0,16'h0000, Z);
    tbl[25] = row(0,1,16'h0400,0,0,0,0,0,0,16'h0000, ex(1,0,16'h0400,0,0,0,0,0));
    tbl[26] = row(0,0,16'h0400,0,0,0,0,0,0,16'h0000, ex(0,0,16'h0400,0,0,0,0,0));
    tbl[27] = row(0,0,16'h0400,0,0,0,0,0,1,16'h0099, ex(0,0,16'h0400,0,0,1,0,16'h0099));
    tbl[28] = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);

    // Tie-break sequence: both ports requesting continuously.
    hs[0]  = row(1,0,0,0,0,0,0,0,0,16'h0000, Z);
    hs[1]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000, Z);
    hs[2]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000, ex(1,0,16'h5000,0,0,0,0,0));
    hs[3]  = row(0,1,16'h3000,1,0,16'h5000,0,0,1,16'h1111, ex(1,0,16'h5000,0,0,0,1,16'h1111));
    hs[4]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000, Z);
    hs[5]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000,
                 RR ? ex(1,0,16'h3000,0,0,0,0,0) : ex(1,0,16'h5000,0,0,0,0,0));
    hs[6]  = row(0,1,16'h3000,1,0,16'h5000,0,0,1,16'h2222,
                 RR ? ex(1,0,16'h3000,0,0,1,0,16'h2222) : ex(1,0,16'h5000,0,0,0,1,16'h2222));
    hs[7]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000, Z);
    hs[8]  = row(0,1,16'h3000,1,0,16'h5000,0,0,0,16'h0000, ex(1,0,16'h5000,0,0,0,0,0));
    hs[9]  = row(0,1,16'h3000,1,0,16'h5000,0,0,1,16'h3333, ex(1,0,16'h5000,0,0,0,1,16'h3333));
    hs[10] = row(0,1,16'h3000,0,0,16'h5000,0,0,0,16'h0000, Z);
    hs[11] = row(0,1,16'h3000,0,0,16'h5000,0,0,0,16'h0000, ex(1,0,16'h3000,0,0,0,0,0));
    hs[12] = row(0,1,16'h3000,0,0,16'h5000,0,0,1,16'h4444, ex(1,0,16'h3000,0,0,1,0,16'h4444));
    hs[13] = row(0,0,0,0,0,0,0,0,0,16'h0000, Z);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) apply(tbl[i], $sformatf("table[%0d]", i));
    for (int i = 0; i < 14; i++) apply(hs[i], $sformatf("tiebreak[%0d]", i));

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_owner = 0;
    m_last  = 1;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 39) == 0);
      i_read        = ($urandom_range(0, 2) != 0);
      i_address     = 16'($urandom);
      d_read        = ($urandom_range(0, 2) == 0);
      d_write       = ($urandom_range(0, 3) == 0);
      d_address     = 16'($urandom);
      d_wdata       = 16'($urandom);
      d_byte_enable = 2'($urandom);
      mem_resp      = ($urandom_range(0, 2) == 0);
      mem_rdata     = 16'($urandom);
      #4;
      check($sformatf("random[%0d]", c), model_out());
      @(posedge clk);
      model_step();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
